// File: rtl/exp_arbiter_pkg.sv
// Shared definitions for the exponent-unit arbiter: FSM encodings, timeout
// default, float constants and a modular increment helper.
package exp_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam int unsigned TimeoutDefault = 64;

  // IEEE-754 single-precision constants
  localparam logic [31:0] FloatZero = 32'h0000_0000;
  localparam logic [31:0] FloatHalf = 32'h3F00_0000;
  localparam logic [31:0] FloatOne  = 32'h3F80_0000;
  localparam logic [31:0] FloatTwo  = 32'h4000_0000;

  // (id + 1) mod n with an explicit wrap, so n need not be a power of two
  function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/exp_arbiter_rr_picker.sv
// Round-robin priority search: first set request bit at or above rr_ptr,
// wrapping at NUM_REQ.
module exp_arbiter_rr_picker #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                any,
  output logic [ID_WIDTH-1:0] grant_id
);

  logic [ID_WIDTH-1:0] idx;

  // Walk offsets 0..NUM_REQ-1 from rr_ptr; the first hit wins
  always_comb begin
    any      = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/exp_arbiter.sv
// Shares one exponent unit between NUM_REQ requesters. Round-robin grant,
// enable-low clear cycle, enable-high run with timeout, one-cycle done pulse.
module exp_arbiter
  import exp_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned TIMEOUT    = TimeoutDefault
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] x_in,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [DATA_WIDTH-1:0]         exp_x,
  output logic                          exp_enable,
  input  logic [DATA_WIDTH-1:0]         exp_output,
  input  logic                          exp_ack
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic                  any;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [DATA_WIDTH-1:0] operand [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_operand
    assign operand[g] = x_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  exp_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .any     (any),
    .grant_id(grant_id)
  );

  // Next-state logic for the job sequencer
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cur_id_d      = cur_id_q;
    x_d           = x_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      StIdle: begin
        if (any) begin
          cur_id_d = grant_id;
          x_d      = operand[grant_id];
          state_d  = StArm;
        end
      end
      StArm: begin
        // Any ack seen here belongs to the previous job; ignore it
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (exp_ack) begin
          result_d = exp_output;
          state_d  = StDone;
        end else if (cnt_q == CntWidth'(TIMEOUT - 1)) begin
          result_d      = '0;
          timeout_err_d = 1'b1;
          state_d       = StDone;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StDone: begin
        rr_ptr_d = ID_WIDTH'(wrap_inc(32'(cur_id_q), NUM_REQ));
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      cur_id_q      <= '0;
      x_q           <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_id_q      <= cur_id_d;
      x_q           <= x_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // One-hot done pulse for the job owner during DONE
  always_comb begin
    done = '0;
    if (state_q == StDone) begin
      done[cur_id_q] = 1'b1;
    end
  end

  assign exp_x       = x_q;
  assign result      = result_q;
  assign timeout_err = timeout_err_q;
  assign exp_enable  = (state_q == StRun);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed bench for exp_arbiter with an exponent-unit stub and a scoreboard
// of expected (owner, value) pairs popped at each done pulse.
module tb_exp_arbiter;
  import exp_arbiter_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 64;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  req;
  logic [NR*DW-1:0] x_in;
  logic [NR-1:0]  done;
  logic [DW-1:0]  result;
  logic           busy;
  logic           timeout_err;
  logic [DW-1:0]  exp_x;
  logic           exp_enable;
  logic [DW-1:0]  exp_output;
  logic           exp_ack;

  int  total;
  int  bad;
  int  en_cnt;
  bit  never_ack;
  bit  force_ack;

  int  sb_id[$];
  real sb_val[$];
  bit  sb_to[$];

  logic [31:0] lane [4];

  exp_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .ID_WIDTH  (IW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .x_in       (x_in),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .timeout_err(timeout_err),
    .exp_x      (exp_x),
    .exp_enable (exp_enable),
    .exp_output (exp_output),
    .exp_ack    (exp_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Exponent stub: acks once enable has been high for 7 cycles
  always @(posedge clk) en_cnt <= exp_enable ? en_cnt + 1 : 0;
  assign exp_ack    = force_ack || (!never_ack && exp_enable && en_cnt == 7);
  assign exp_output = r2f($exp(f2r(exp_x)));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input real obs, input real expv);
    total++;
    assert ((obs - expv) < 1e-4 && (expv - obs) < 1e-4) else begin
      bad++;
      $error("FAIL %s: got %f want %f", tag, obs, expv);
    end
  endtask

  task automatic push(input int id, input logic [31:0] x, input bit to);
    sb_id.push_back(id);
    sb_val.push_back(to ? 0.0 : $exp(f2r(x)));
    sb_to.push_back(to);
  endtask

  // Step until a done pulse or the limit; returns cycles stepped
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      step();
      cyc++;
      if (done != '0) break;
    end
    chk("done_seen", 32'(done != '0), 32'd1);
  endtask

  // Compare the current done cycle against the oldest scoreboard entry
  task automatic check_done(input string tag);
    int  id;
    real v;
    bit  to;
    if (sb_id.size() == 0) begin
      chk({tag, "_sb"}, 32'(sb_id.size()), 32'd1);
      return;
    end
    id = sb_id.pop_front();
    v  = sb_val.pop_front();
    to = sb_to.pop_front();
    chk({tag, "_done"}, 32'(done), 32'(1 << id));
    chk({tag, "_done_en"}, 32'(exp_enable), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    if (to) chk({tag, "_res0"}, result, 32'h0);
    else    chk_near({tag, "_res"}, f2r(result), v);
  endtask

  task automatic run_job(input string tag, input logic [3:0] r, input int id,
                         input logic [31:0] x, input int lat);
    int cyc;
    x_in[id*32 +: 32] = x;
    req = r;
    push(id, x, 1'b0);
    step();
    chk({tag, "_arm_en"}, 32'(exp_enable), 32'd0);
    chk({tag, "_arm_busy"}, 32'(busy), 32'd1);
    chk({tag, "_exp_x"}, exp_x, x);
    step();
    chk({tag, "_run_en"}, 32'(exp_enable), 32'd1);
    wait_done(lat + 5, cyc);
    chk({tag, "_lat"}, 32'(cyc + 2), 32'(lat));
    check_done(tag);
    req = '0;
    step();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
    chk({tag, "_exp_x"}, exp_x, 32'h0);
    chk({tag, "_exp_en"}, 32'(exp_enable), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req       = '0;
    x_in      = '0;
    never_ack = 1'b0;
    force_ack = 1'b0;
    lane[0]   = FloatHalf;
    lane[1]   = FloatOne;
    lane[2]   = 32'hBF80_0000;
    lane[3]   = FloatTwo;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Single request, latency and value
    run_job("single", 4'b0001, 0, 32'h3F566CF4, 10);
    chk_near("single_val", f2r(result), 2.3108);

    // All requesting after reset: order 0,1,2,3,0
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) x_in[i*32 +: 32] = lane[i];
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      push(j % 4, lane[j % 4], 1'b0);
      wait_done(20, cyc);
      chk("rr_lat", 32'(cyc), 32'd10);
      check_done("rr");
      if (j == 4) req = '0;
      step();
      chk("rr_gap_busy", 32'(busy), 32'd0);
      chk("rr_gap_done", 32'(done), 32'd0);
    end

    // Negative operand; operand change and req drop during RUN
    x_in[64 +: 32] = 32'hBF75C28F;
    req = 4'b0100;
    push(2, 32'hBF75C28F, 1'b0);
    step();
    step();
    x_in[64 +: 32] = FloatOne;
    req = '0;
    step();
    chk("neg_exp_x_hold", exp_x, 32'hBF75C28F);
    wait_done(20, cyc);
    chk("neg_lat", 32'(cyc + 3), 32'd10);
    check_done("neg");
    chk_near("neg_val", f2r(result), 0.3829);
    step();

    // Stale ack during ARM is ignored
    x_in[96 +: 32] = FloatOne;
    req = 4'b1000;
    push(3, FloatOne, 1'b0);
    step();
    force_ack = 1'b1;
    chk("arm_ack_en", 32'(exp_enable), 32'd0);
    step();
    force_ack = 1'b0;
    chk("arm_ack_run_en", 32'(exp_enable), 32'd1);
    wait_done(20, cyc);
    chk("arm_ack_lat", 32'(cyc + 2), 32'd10);
    check_done("arm_ack");
    req = '0;
    step();

    // Unit never acks: abort after TIMEOUT run cycles
    never_ack = 1'b1;
    x_in[0 +: 32] = 32'h4040_0000;
    req = 4'b0001;
    push(0, 32'h4040_0000, 1'b1);
    wait_done(TO + 10, cyc);
    chk("to_lat", 32'(cyc), 32'(TO + 2));
    check_done("to");
    chk("to_err", 32'(timeout_err), 32'd1);
    req = '0;
    step();
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    never_ack = 1'b0;
    run_job("after_to", 4'b0001, 0, FloatTwo, 10);
    chk("after_to_err", 32'(timeout_err), 32'd1);

    // Reset in RUN of requester 1, then search restarts from 0
    x_in[32 +: 32] = FloatOne;
    req = 4'b0010;
    step();
    step();
    step();
    step();
    chk("mid_run_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    step();
    chk("rst_no_done", 32'(done), 32'd0);
    reset = 1'b0;
    x_in[0 +: 32] = FloatHalf;
    req = 4'b0011;
    push(0, FloatHalf, 1'b0);
    wait_done(20, cyc);
    chk("post_rst_lat", 32'(cyc), 32'd10);
    check_done("post_rst");
    req = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
